frame_addr_uart_rx: RTL and testbench
=====================================

FRAME_ADDR_UART_RX -- requirements
Module: frame_addr_uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate.
REQ-003 SHALL have parameter GAP_CYC, default 5000000, inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-high despite the suffix.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous UART line, 8N1, idle high.
REQ-007 SHALL have port done  input  1  one-cycle pulse from the injection writer: frame finished.
REQ-008 SHALL have port frameaddr  output  32  assembled frame address, held stable until the next issue.
REQ-009 SHALL have port start  output  1  one-cycle pulse: frameaddr valid, injection begins.
REQ-010 SHALL have port busy  output  1  high from the start pulse until done is seen.
REQ-011 SHALL have port err  output  1  one-cycle pulse on framing error, timeout or overrun.

Function
REQ-012 SHALL synchronise uart_rxd through two flip-flops before any use.
REQ-013 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), 434 at defaults.
REQ-014 SHALL detect start on a synchronised high-to-low transition, recheck low at CLKS_PER_BIT/2, and reject as a glitch if high (no err).
REQ-015 SHALL sample 8 data bits LSB-first, each at its bit centre, then the stop bit at its centre.
REQ-016 SHALL, on stop bit = 0, discard the byte and any partial word, and pulse err.
REQ-017 SHALL assemble 4 valid bytes big-endian: first byte to frameaddr[31:24], fourth byte to [7:0].
REQ-018 SHALL have assembler states IDLE (0 bytes), COLLECT (1-3 bytes), ISSUE and WAIT_DONE.
REQ-019 SHALL move IDLE->COLLECT on the first byte, COLLECT->ISSUE on the fourth byte, ISSUE->WAIT_DONE after one cycle, and WAIT_DONE->IDLE on done.
REQ-020 SHALL load frameaddr and pulse start in the ISSUE cycle, one cycle after the fourth byte's stop-bit sample; busy rises in the same cycle.
REQ-021 SHALL drop a partial word, return to IDLE and pulse err once if GAP_CYC cycles pass in COLLECT without a new byte.
REQ-022 SHALL, in WAIT_DONE, count arriving bytes; on the 4th byte it SHALL drop the word and pulse err (overrun), so frameaddr never changes while busy.
REQ-023 SHALL ignore done when not in WAIT_DONE; done in the same cycle as a byte completion SHALL be processed first and the byte counted toward a new word.
REQ-024 SHALL give err at most one pulse per cycle when error events coincide.

Reset
REQ-025 SHALL, on rst_n = 1, clear frameaddr to 32'h0 and start, busy and err to 0, and set the UART receiver idle, the assembler to IDLE and the byte and gap counters to 0.
REQ-026 SHALL abandon an in-flight byte or word on reset and need a fresh start edge afterwards.

Structure
REQ-027 SHALL use a shared package for the assembler state encoding, the UART receiver state encoding and CLKS_PER_BIT derivation.
REQ-028 SHALL use one sub-module, uart_rx_byte (synchroniser, bit timing, byte plus valid pulse plus frame_err pulse), instantiated once.

Verification
REQ-029 SHALL use CLK_FREQ=1000000, BAUD=100000 (10 clk/bit) and GAP_CYC=200 in all directed scenarios below.
REQ-030 Verification SHALL cover the nominal case: send bytes 0x00,0x40,0x1A,0x80 -> one start pulse, frameaddr=32'h00401A80, busy=1; done pulse -> busy=0.
REQ-031 Verification SHALL cover a framing error: send 0x12 with stop bit forced 0, then 4 valid bytes 0xDE,0xAD,0xBE,0xEF -> one err pulse, then frameaddr=32'hDEADBEEF.
REQ-032 Verification SHALL cover the timeout: send 2 bytes, then idle 250 cycles -> err pulse, no start; the next 4 bytes yield a correct word.
REQ-033 Verification SHALL cover overrun: while busy, send 4 bytes -> err pulse, frameaddr unchanged, no start.
REQ-034 Verification SHALL cover a glitch: a 3-cycle low pulse on uart_rxd -> no byte, no err.
REQ-035 Verification SHALL cover reset mid-word: assert rst_n after 2 bytes, then send 4 bytes -> frameaddr reflects only the last 4 bytes.

Source files
------------

// File: rtl/frame_addr_uart_rx_pkg.sv
// Shared encodings and bit-timing derivation for the frame-address UART receiver.
package frame_addr_uart_rx_pkg;

    typedef enum logic [1:0] {
        ASM_IDLE,
        ASM_COLLECT,
        ASM_ISSUE,
        ASM_WAIT_DONE
    } asm_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/frame_addr_uart_rx_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser, centre sampling, valid / framing-error pulses.
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | half-bit wait, then confirm start bit is still low
// RX_DATA  | sampling 8 data bits LSB-first at bit centres
// RX_STOP  | sampling stop bit; high -> valid, low -> framing error
module uart_rx_byte
    import frame_addr_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int unsigned HALF = (CPB / 2 > 0) ? CPB / 2 : 1;
    localparam int unsigned CW   = $clog2(CPB + 1);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;

    // Synchroniser is left out of reset so a line held low across reset is not seen as a new edge.
    always_ff @(posedge clk) begin
        rxd_meta_q <= rxd_i;
        rxd_sync_q <= rxd_meta_q;
        rxd_prev_q <= rxd_sync_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        valid_o     = 1'b0;
        frame_err_o = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    state_d = RX_START;
                    cnt_d   = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rxd_sync_q) begin
                        state_d = RX_DATA;
                        cnt_d   = CNT_BIT;
                        bit_d   = '0;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    cnt_d   = CNT_BIT;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    valid_o     = rxd_sync_q;
                    frame_err_o = !rxd_sync_q;
                    state_d     = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o = shift_q;

endmodule

// File: rtl/frame_addr_uart_rx.sv
// Assembles four UART bytes big-endian into a frame address and hands it to the injection writer.
// state         | meaning
// ASM_IDLE      | no bytes of a word held
// ASM_COLLECT   | 1-3 bytes held, gap timer running
// ASM_ISSUE     | frameaddr loaded, start pulse
// ASM_WAIT_DONE | writer busy; arriving bytes counted toward overrun
module frame_addr_uart_rx
    import frame_addr_uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned GAP_CYC  = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rxd,
    input  logic        done,
    output logic [31:0] frameaddr,
    output logic        start,
    output logic        busy,
    output logic        err
);

    localparam int unsigned GW = $clog2(GAP_CYC + 1);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_CYC - 1);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ferr;

    asm_state_e    state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [23:0]   word_q, word_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx_byte (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd_i       (uart_rxd),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ASM_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            gap_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            gap_q   <= gap_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        gap_d   = gap_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        case (state_q)
            ASM_IDLE: begin
                if (rx_ferr) begin
                    err_d = 1'b1;
                end else if (rx_valid) begin
                    word_d  = {word_q[15:0], rx_byte};
                    cnt_d   = 2'd1;
                    gap_d   = GAP_RELOAD;
                    state_d = ASM_COLLECT;
                end
            end
            ASM_COLLECT: begin
                if (rx_ferr) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ASM_IDLE;
                end else if (rx_valid) begin
                    if (cnt_q == 2'd3) begin
                        addr_d  = {word_q, rx_byte};
                        cnt_d   = '0;
                        state_d = ASM_ISSUE;
                    end else begin
                        word_d = {word_q[15:0], rx_byte};
                        cnt_d  = cnt_q + 2'd1;
                        gap_d  = GAP_RELOAD;
                    end
                end else if (gap_q == '0) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ASM_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            ASM_ISSUE, ASM_WAIT_DONE: begin
                if (state_q == ASM_ISSUE) begin
                    state_d = ASM_WAIT_DONE;
                end
                // done wins over a coinciding byte; that byte opens the next word.
                if (state_q == ASM_WAIT_DONE && done) begin
                    cnt_d   = '0;
                    state_d = ASM_IDLE;
                    if (rx_ferr) begin
                        err_d = 1'b1;
                    end else if (rx_valid) begin
                        word_d  = {word_q[15:0], rx_byte};
                        cnt_d   = 2'd1;
                        gap_d   = GAP_RELOAD;
                        state_d = ASM_COLLECT;
                    end
                end else if (rx_ferr) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else if (rx_valid) begin
                    if (cnt_q == 2'd3) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ASM_IDLE;
        endcase
    end

    assign frameaddr = addr_q;
    assign start     = (state_q == ASM_ISSUE);
    assign busy      = (state_q == ASM_ISSUE) || (state_q == ASM_WAIT_DONE);
    assign err       = err_q;

endmodule

// File: tb/tb_frame_addr_uart_rx.sv
// Directed bench for frame_addr_uart_rx at 10 clocks per bit and a 200-cycle gap timeout.
module tb_frame_addr_uart_rx;

    localparam int unsigned CLK_FREQ = 1000000;
    localparam int unsigned BAUD     = 100000;
    localparam int unsigned GAP_CYC  = 200;
    localparam int BIT_CYC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        uart_rxd = 1'b1;
    logic        done = 1'b0;
    logic [31:0] frameaddr;
    logic        start;
    logic        busy;
    logic        err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          start_seen = 0;
    int          err_seen   = 0;
    logic [31:0] start_addr = 32'h0;

    frame_addr_uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rxd  (uart_rxd),
        .done      (done),
        .frameaddr (frameaddr),
        .start     (start),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start) begin
            start_seen = start_seen + 1;
            start_addr = frameaddr;
        end
        if (err) begin
            err_seen = err_seen + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running, expected finish before time limit");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] data;
        data = b;
        uart_rxd = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = data[i];
            wait_cyc(BIT_CYC);
        end
        uart_rxd = stop_bit;
        wait_cyc(BIT_CYC);
        uart_rxd = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        wait_cyc(1);
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        wait_cyc(4);
        rst_n = 1'b0;
        wait_cyc(2);
        total_cnt++;
        if (frameaddr !== 32'h0) $display("FAIL reset_frameaddr: got %h expected %h", frameaddr, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (start !== 1'b0) $display("FAIL reset_start: got %b expected 0", start);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
        else pass_cnt++;
    endtask

    task automatic test_nominal();
        int s0, e0;
        s0 = start_seen;
        e0 = err_seen;
        send_word(32'h00401A80);
        wait_cyc(3);
        total_cnt++;
        if (start_seen - s0 !== 1) $display("FAIL nominal_start_count: got %0d expected 1", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (start_addr !== 32'h00401A80) $display("FAIL nominal_addr_at_start: got %h expected %h", start_addr, 32'h00401A80);
        else pass_cnt++;
        total_cnt++;
        if (frameaddr !== 32'h00401A80) $display("FAIL nominal_frameaddr: got %h expected %h", frameaddr, 32'h00401A80);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL nominal_busy: got %b expected 1", busy);
        else pass_cnt++;
        total_cnt++;
        if (err_seen - e0 !== 0) $display("FAIL nominal_err_count: got %0d expected 0", err_seen - e0);
        else pass_cnt++;
        pulse_done();
        wait_cyc(2);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL nominal_busy_after_done: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_framing();
        int s0, e0;
        s0 = start_seen;
        e0 = err_seen;
        send_frame(8'h12, 1'b0);
        wait_cyc(10);
        total_cnt++;
        if (err_seen - e0 !== 1) $display("FAIL framing_err_count: got %0d expected 1", err_seen - e0);
        else pass_cnt++;
        send_word(32'hDEADBEEF);
        wait_cyc(3);
        total_cnt++;
        if (start_seen - s0 !== 1) $display("FAIL framing_start_count: got %0d expected 1", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (frameaddr !== 32'hDEADBEEF) $display("FAIL framing_frameaddr: got %h expected %h", frameaddr, 32'hDEADBEEF);
        else pass_cnt++;
        total_cnt++;
        if (err_seen - e0 !== 1) $display("FAIL framing_err_total: got %0d expected 1", err_seen - e0);
        else pass_cnt++;
        pulse_done();
        wait_cyc(2);
    endtask

    task automatic test_timeout();
        int s0, e0;
        s0 = start_seen;
        e0 = err_seen;
        send_byte(8'h11);
        send_byte(8'h22);
        wait_cyc(250);
        total_cnt++;
        if (err_seen - e0 !== 1) $display("FAIL timeout_err_count: got %0d expected 1", err_seen - e0);
        else pass_cnt++;
        total_cnt++;
        if (start_seen - s0 !== 0) $display("FAIL timeout_no_start: got %0d expected 0", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL timeout_busy: got %b expected 0", busy);
        else pass_cnt++;
        send_word(32'h01234567);
        wait_cyc(3);
        total_cnt++;
        if (start_seen - s0 !== 1) $display("FAIL timeout_next_start: got %0d expected 1", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (frameaddr !== 32'h01234567) $display("FAIL timeout_next_frameaddr: got %h expected %h", frameaddr, 32'h01234567);
        else pass_cnt++;
        pulse_done();
        wait_cyc(2);
    endtask

    task automatic test_overrun();
        int s0, e0;
        s0 = start_seen;
        e0 = err_seen;
        send_word(32'hCAFEBABE);
        wait_cyc(3);
        total_cnt++;
        if (start_seen - s0 !== 1) $display("FAIL overrun_first_start: got %0d expected 1", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL overrun_busy_first: got %b expected 1", busy);
        else pass_cnt++;
        send_word(32'h11223344);
        wait_cyc(3);
        total_cnt++;
        if (err_seen - e0 !== 1) $display("FAIL overrun_err_count: got %0d expected 1", err_seen - e0);
        else pass_cnt++;
        total_cnt++;
        if (start_seen - s0 !== 1) $display("FAIL overrun_no_start: got %0d expected 1", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (frameaddr !== 32'hCAFEBABE) $display("FAIL overrun_frameaddr: got %h expected %h", frameaddr, 32'hCAFEBABE);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL overrun_busy_held: got %b expected 1", busy);
        else pass_cnt++;
        pulse_done();
        wait_cyc(2);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL overrun_busy_after_done: got %b expected 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int s0, e0;
        s0 = start_seen;
        e0 = err_seen;
        uart_rxd = 1'b0;
        wait_cyc(3);
        uart_rxd = 1'b1;
        wait_cyc(20);
        total_cnt++;
        if (err_seen - e0 !== 0) $display("FAIL glitch_err: got %0d expected 0", err_seen - e0);
        else pass_cnt++;
        send_word(32'h5AA50FF0);
        wait_cyc(3);
        total_cnt++;
        if (start_seen - s0 !== 1) $display("FAIL glitch_start_count: got %0d expected 1", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (frameaddr !== 32'h5AA50FF0) $display("FAIL glitch_frameaddr: got %h expected %h", frameaddr, 32'h5AA50FF0);
        else pass_cnt++;
        total_cnt++;
        if (err_seen - e0 !== 0) $display("FAIL glitch_err_total: got %0d expected 0", err_seen - e0);
        else pass_cnt++;
        pulse_done();
        wait_cyc(2);
    endtask

    task automatic test_reset_mid_word();
        int s0, e0;
        send_byte(8'h99);
        send_byte(8'h88);
        uart_rxd = 1'b0;
        wait_cyc(25);
        rst_n = 1'b1;
        wait_cyc(2);
        rst_n = 1'b0;
        total_cnt++;
        if (frameaddr !== 32'h0) $display("FAIL midreset_frameaddr_cleared: got %h expected %h", frameaddr, 32'h0);
        else pass_cnt++;
        s0 = start_seen;
        e0 = err_seen;
        wait_cyc(5);
        uart_rxd = 1'b1;
        wait_cyc(30);
        send_word(32'h13579BDF);
        wait_cyc(3);
        total_cnt++;
        if (start_seen - s0 !== 1) $display("FAIL midreset_start_count: got %0d expected 1", start_seen - s0);
        else pass_cnt++;
        total_cnt++;
        if (frameaddr !== 32'h13579BDF) $display("FAIL midreset_frameaddr: got %h expected %h", frameaddr, 32'h13579BDF);
        else pass_cnt++;
        total_cnt++;
        if (err_seen - e0 !== 0) $display("FAIL midreset_err: got %0d expected 0", err_seen - e0);
        else pass_cnt++;
        pulse_done();
        wait_cyc(2);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_framing();
        test_timeout();
        test_overrun();
        test_glitch();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
